// File: rtl/serial_id_pkg.sv
// Shared types and helpers for the serial ID reader: FSM states, word-count helper,
// and status-word bit positions.
package serial_id_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  localparam int STAT_VALID_BIT = 31;
  localparam int STAT_BUSY_BIT  = 30;
  localparam int STAT_COUNT_W   = 16;

  function automatic int words_for(input int width);
    return (width + 31) / 32;
  endfunction

endpackage

// File: rtl/serial_id_shifter.sv
// Drives a DNA_PORT-style device at a divided clock and captures its serial ID MSB first;
// the shadow id only changes, in one cycle, when a full capture completes.
module serial_id_shifter
  import serial_id_pkg::*;
#(
  parameter int ID_WIDTH    = 57,
  parameter int HALF_PERIOD = 16
) (
  input  logic                clk_48,
  input  logic                rst_n,
  input  logic                start,
  output logic                sid_clk,
  output logic                sid_read,
  output logic                sid_shift,
  input  logic                sid_dout,
  output logic [ID_WIDTH-1:0] id,
  output logic                id_valid,
  output logic                busy,
  output logic                done
);

  localparam int DW = $clog2(HALF_PERIOD);
  localparam int CW = $clog2(ID_WIDTH + 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(ID_WIDTH - 1);

  state_t              state;
  logic [DW-1:0]       div;
  logic [CW-1:0]       bit_cnt;
  logic [ID_WIDTH-1:0] shreg;
  logic [ID_WIDTH-1:0] shreg_next;

  assign shreg_next = {shreg[ID_WIDTH-2:0], sid_dout};
  assign busy       = (state != IDLE);

  always_ff @(posedge clk_48) begin
    if (!rst_n) begin
      state     <= IDLE;
      div       <= DIV_LOAD;
      sid_clk   <= 1'b0;
      sid_read  <= 1'b0;
      sid_shift <= 1'b0;
      bit_cnt   <= '0;
      id        <= '0;
      id_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        div     <= DIV_LOAD;
        sid_clk <= 1'b0;
        if (start) state <= LOAD;
      end else if (div != '0) begin
        div <= div - 1'b1;
      end else begin
        div     <= DIV_LOAD;
        sid_clk <= ~sid_clk;
        // Falling edge of sid_clk: the only point where pins move and data is sampled
        if (sid_clk) begin
          case (state)
            LOAD: begin
              if (!sid_read) begin
                sid_read <= 1'b1;
              end else begin
                sid_read  <= 1'b0;
                sid_shift <= 1'b1;
                shreg     <= shreg_next;
                bit_cnt   <= CW'(1);
                state     <= SHIFT;
              end
            end
            SHIFT: begin
              shreg   <= shreg_next;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                sid_shift <= 1'b0;
                id        <= shreg_next;
                id_valid  <= 1'b1;
                done      <= 1'b1;
                state     <= IDLE;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/axi_serial_id_reader.sv
// Serial ID reader with a register window: ID words, a status/control word with a
// capture counter, and a software start that is ignored while a capture is running.
module axi_serial_id_reader
  import serial_id_pkg::*;
#(
  parameter int ID_WIDTH    = 57,
  parameter int HALF_PERIOD = 16,
  parameter int ADDR_BITS   = 2,
  parameter int AUTO_START  = 1
) (
  input  logic                 clk_48,
  input  logic                 rst_n,
  input  logic                 avalid,
  output logic                 aready,
  input  logic [ADDR_BITS+1:2] aaddr,
  input  logic                 awrite,
  input  logic [31:0]          awdata,
  output logic                 bvalid,
  output logic [31:0]          bdata,
  output logic                 sid_clk,
  output logic                 sid_read,
  output logic                 sid_shift,
  input  logic                 sid_dout,
  output logic [ID_WIDTH-1:0]  id,
  output logic                 id_valid
);

  localparam int NW = words_for(ID_WIDTH);
  localparam logic [ADDR_BITS-1:0] STATUS_ADDR = ADDR_BITS'(NW);

  logic                    busy;
  logic                    done;
  logic                    start_pend;
  logic                    launch;
  logic                    start_wr;
  logic [STAT_COUNT_W-1:0] count;
  logic [NW*32-1:0]        id_pad;
  logic [31:0]             status_word;
  logic [31:0]             rdata;
  logic                    unused_wdata;

  serial_id_shifter #(
    .ID_WIDTH    (ID_WIDTH),
    .HALF_PERIOD (HALF_PERIOD)
  ) u_shifter (
    .clk_48    (clk_48),
    .rst_n     (rst_n),
    .start     (start_pend),
    .sid_clk   (sid_clk),
    .sid_read  (sid_read),
    .sid_shift (sid_shift),
    .sid_dout  (sid_dout),
    .id        (id),
    .id_valid  (id_valid),
    .busy      (busy),
    .done      (done)
  );

  assign aready       = bvalid;
  assign unused_wdata = ^awdata[31:1];
  assign launch       = start_pend & ~busy;
  // busy is sampled before the completing edge, so a start landing on completion is dropped
  assign start_wr     = bvalid & avalid & awrite & (aaddr == STATUS_ADDR) & awdata[0] & ~busy;

  always_comb begin
    status_word                   = '0;
    status_word[STAT_VALID_BIT]   = id_valid;
    status_word[STAT_BUSY_BIT]    = busy;
    status_word[STAT_COUNT_W-1:0] = count;
    id_pad                        = '0;
    id_pad[ID_WIDTH-1:0]          = id;
    rdata                         = '0;
    if (aaddr == STATUS_ADDR) rdata = status_word;
    for (int i = 0; i < NW; i++) begin
      if (aaddr == ADDR_BITS'(i)) rdata = id_pad[32*i +: 32];
    end
  end

  always_ff @(posedge clk_48) begin
    if (!rst_n) begin
      bvalid     <= 1'b0;
      bdata      <= '0;
      start_pend <= (AUTO_START != 0);
      count      <= '0;
    end else begin
      bvalid <= avalid & ~bvalid;
      if (avalid && !bvalid) bdata <= rdata;
      if (launch) start_pend <= 1'b0;
      else if (start_wr) start_pend <= 1'b1;
      if (done) count <= count + 1'b1;
    end
  end

endmodule
